// File: rtl/block_padder_pkg.sv
// Shared rate/word geometry and FSM encoding for the keccak absorb-side padder.
package block_padder_pkg;

    localparam int unsigned RATE_WORDS = 18;
    localparam int unsigned WORD_W     = 32;
    localparam int unsigned RATE_W     = 576;
    localparam int unsigned CNT_W      = 5;

    localparam logic [CNT_W-1:0] CNT_LAST_SLOT = CNT_W'(RATE_WORDS - 1);
    localparam logic [CNT_W-1:0] CNT_FULL      = CNT_W'(RATE_WORDS);

    localparam logic [2:0] ST_ABSORB    = 3'd0;
    localparam logic [2:0] ST_FILL      = 3'd1;
    localparam logic [2:0] ST_FULL      = 3'd2;
    localparam logic [2:0] ST_FULL_LAST = 3'd3;
    localparam logic [2:0] ST_DONE      = 3'd4;

    // Final-bit marker of the multi-rate padding, carried by the last word of the last block.
    function automatic logic [WORD_W-1:0] mark_final(input logic [WORD_W-1:0] w);
        return w | {{(WORD_W-8){1'b0}}, 8'h80};
    endfunction

endpackage

// File: rtl/block_padder_pad_word.sv
// Masks bytes past byte_num in the final message word and inserts the domain-separation byte.
module pad_word
    import block_padder_pkg::*;
#(
    parameter logic [7:0] PAD_BYTE = 8'h01
) (
    input  logic [WORD_W-1:0] in,
    input  logic [1:0]        byte_num,
    input  logic              is_last,
    output logic [WORD_W-1:0] out
);

    always_comb begin
        out = in;
        if (is_last) begin
            case (byte_num)
                2'd0:    out = {PAD_BYTE, 24'h0};
                2'd1:    out = {in[31:24], PAD_BYTE, 16'h0};
                2'd2:    out = {in[31:16], PAD_BYTE, 8'h0};
                default: out = {in[31:8], PAD_BYTE};
            endcase
        end
    end

endmodule

// File: rtl/block_padder.sv
// Packs 32-bit message words into 576-bit rate blocks and appends keccak padding.
module block_padder
    import block_padder_pkg::*;
#(
    parameter logic [7:0] PAD_BYTE = 8'h01
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [31:0]       in,
    input  logic              in_ready,
    input  logic              is_last,
    input  logic [1:0]        byte_num,
    output logic              ack,
    output logic [575:0]      out,
    output logic              out_ready,
    input  logic              f_ack
);

    logic [2:0]        state;
    logic [CNT_W-1:0]  counter;
    logic              last_seen;
    logic [WORD_W-1:0] padded;
    logic [WORD_W-1:0] next_word;
    logic              fill_en;
    logic              shift_en;
    logic              slot_last;
    logic              word_final;

    pad_word #(.PAD_BYTE(PAD_BYTE)) u_pad_word (
        .in       (in),
        .byte_num (byte_num),
        .is_last  (is_last),
        .out      (padded)
    );

    assign ack = in_ready & ~out_ready & ~last_seen & ~reset;

    always_comb begin
        fill_en    = (state == ST_FILL) && last_seen && !out_ready && (counter < CNT_FULL);
        shift_en   = ack | fill_en;
        slot_last  = (counter == CNT_LAST_SLOT);
        word_final = fill_en | is_last;
        next_word  = fill_en ? '0 : padded;
        if (slot_last && word_final)
            next_word = mark_final(next_word);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            out       <= '0;
            out_ready <= 1'b0;
            counter   <= '0;
            last_seen <= 1'b0;
            state     <= ST_ABSORB;
        end else if (shift_en) begin
            out     <= {out[RATE_W-WORD_W-1:0], next_word};
            counter <= counter + 1'b1;
            if (ack && is_last)
                last_seen <= 1'b1;
            if (slot_last) begin
                out_ready <= 1'b1;
                state     <= word_final ? ST_FULL_LAST : ST_FULL;
            end else if (ack && is_last) begin
                state <= ST_FILL;
            end
        end else if (out_ready && f_ack) begin
            // Releasing the final block parks the padder; a fresh message needs reset.
            out_ready <= 1'b0;
            counter   <= '0;
            state     <= (state == ST_FULL_LAST) ? ST_DONE : ST_ABSORB;
        end
    end

endmodule

// File: tb/tb_block_padder.sv
// Directed self-checking bench for block_padder.
module tb_block_padder;

    logic         clk;
    logic         reset;
    logic [31:0]  in;
    logic         in_ready;
    logic         is_last;
    logic [1:0]   byte_num;
    logic         ack;
    logic [575:0] out;
    logic         out_ready;
    logic         f_ack;

    int passed = 0;
    int total  = 0;

    block_padder #(.PAD_BYTE(8'h01)) dut (
        .clk       (clk),
        .reset     (reset),
        .in        (in),
        .in_ready  (in_ready),
        .is_last   (is_last),
        .byte_num  (byte_num),
        .ack       (ack),
        .out       (out),
        .out_ready (out_ready),
        .f_ack     (f_ack)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic do_reset();
        reset    = 1'b1;
        in_ready = 1'b0;
        is_last  = 1'b0;
        f_ack    = 1'b0;
        @(posedge clk); #1;
        reset = 1'b0;
    endtask

    task automatic send_word(input logic [31:0] w, input logic last,
                             input logic [1:0] bn, output logic got);
        in       = w;
        is_last  = last;
        byte_num = bn;
        in_ready = 1'b1;
        @(negedge clk);
        got = ack;
        @(posedge clk); #1;
        in_ready = 1'b0;
        is_last  = 1'b0;
    endtask

    task automatic wait_full(input int max, output int n);
        n = -1;
        for (int i = 1; i <= max; i++) begin
            @(posedge clk); #1;
            if (out_ready) begin
                n = i;
                break;
            end
        end
    endtask

    function automatic logic [575:0] pad_only_block();
        logic [575:0] b;
        b = '0;
        b[575:544] = 32'h01000000;
        b[31:0]    = 32'h00000080;
        return b;
    endfunction

    task automatic test_reset();
        reset    = 1'b1;
        in_ready = 1'b1;
        f_ack    = 1'b0;
        is_last  = 1'b0;
        byte_num = 2'd0;
        in       = 32'hFFFFFFFF;
        @(negedge clk);
        total++; if (ack !== 1'b0) $display("FAIL reset_ack: got %b expected 0", ack); else passed++;
        @(posedge clk); #1;
        total++; if (out !== '0) $display("FAIL reset_out: got %h expected 0", out); else passed++;
        total++; if (out_ready !== 1'b0) $display("FAIL reset_out_ready: got %b expected 0", out_ready); else passed++;
        reset    = 1'b0;
        in_ready = 1'b0;
    endtask

    task automatic test_empty();
        logic got;
        int   n;
        do_reset();
        send_word(32'h00000000, 1'b1, 2'd0, got);
        total++; if (got !== 1'b1) $display("FAIL empty_ack: got %b expected 1", got); else passed++;
        wait_full(30, n);
        total++; if (n != 17) $display("FAIL empty_latency: got %0d expected 17", n); else passed++;
        total++; if (out !== pad_only_block()) $display("FAIL empty_block: got %h expected %h", out, pad_only_block()); else passed++;
        in_ready = 1'b1;
        @(negedge clk);
        total++; if (ack !== 1'b0) $display("FAIL empty_full_ack: got %b expected 0", ack); else passed++;
        @(posedge clk); #1;
        f_ack = 1'b1;
        @(posedge clk); #1;
        f_ack = 1'b0;
        total++; if (out_ready !== 1'b0) $display("FAIL done_out_ready: got %b expected 0", out_ready); else passed++;
        @(negedge clk);
        total++; if (ack !== 1'b0) $display("FAIL done_ack: got %b expected 0", ack); else passed++;
        repeat (3) @(posedge clk);
        #1;
        total++; if (out_ready !== 1'b0) $display("FAIL done_stays: got %b expected 0", out_ready); else passed++;
        in_ready = 1'b0;
    endtask

    task automatic test_three_byte();
        logic got;
        int   n;
        do_reset();
        send_word(32'hAABBCC00, 1'b1, 2'd3, got);
        wait_full(30, n);
        total++; if (out[575:544] !== 32'hAABBCC01) $display("FAIL three_first: got %h expected aabbcc01", out[575:544]); else passed++;
        total++; if (out[31:0] !== 32'h00000080) $display("FAIL three_last: got %h expected 00000080", out[31:0]); else passed++;
        total++; if (out[543:32] !== '0) $display("FAIL three_middle: got %h expected 0", out[543:32]); else passed++;
    endtask

    task automatic test_partial();
        logic        got;
        int          n;
        logic [31:0] exp_first [2];
        exp_first[0] = 32'hDE010000;
        exp_first[1] = 32'hDEAD0100;
        for (int k = 0; k < 2; k++) begin
            do_reset();
            send_word(32'hDEADBEEF, 1'b1, 2'(k + 1), got);
            wait_full(30, n);
            total++;
            if (out[575:544] !== exp_first[k])
                $display("FAIL partial_bn%0d: got %h expected %h", k + 1, out[575:544], exp_first[k]);
            else passed++;
        end
    endtask

    task automatic test_back_to_back();
        logic         got;
        logic         all_ack;
        logic [575:0] exp;
        logic [31:0]  w;
        int           n;
        do_reset();
        exp     = '0;
        all_ack = 1'b1;
        for (int i = 0; i < 18; i++) begin
            w = 32'hC0DE0000 + 32'(i);
            exp[575 - 32*i -: 32] = w;
            send_word(w, 1'b0, 2'd0, got);
            all_ack &= got;
        end
        total++; if (all_ack !== 1'b1) $display("FAIL b2b_all_ack: got %b expected 1", all_ack); else passed++;
        total++; if (out_ready !== 1'b1) $display("FAIL b2b_ready: got %b expected 1", out_ready); else passed++;
        total++; if (out !== exp) $display("FAIL b2b_block1: got %h expected %h", out, exp); else passed++;
        in       = 32'h00000000;
        is_last  = 1'b1;
        byte_num = 2'd0;
        in_ready = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            total++; if (ack !== 1'b0) $display("FAIL b2b_hold_ack%0d: got %b expected 0", c, ack); else passed++;
        end
        @(posedge clk); #1;
        f_ack = 1'b1;
        @(negedge clk);
        total++; if (ack !== 1'b0) $display("FAIL b2b_fack_ack: got %b expected 0", ack); else passed++;
        @(posedge clk); #1;
        f_ack = 1'b0;
        total++; if (out_ready !== 1'b0) $display("FAIL b2b_released: got %b expected 0", out_ready); else passed++;
        total++; if (out !== exp) $display("FAIL b2b_out_held: got %h expected %h", out, exp); else passed++;
        @(negedge clk);
        total++; if (ack !== 1'b1) $display("FAIL b2b_resume_ack: got %b expected 1", ack); else passed++;
        @(posedge clk); #1;
        in_ready = 1'b0;
        is_last  = 1'b0;
        wait_full(30, n);
        total++; if (n != 17) $display("FAIL b2b_pad_latency: got %0d expected 17", n); else passed++;
        total++; if (out !== pad_only_block()) $display("FAIL b2b_pad_block: got %h expected %h", out, pad_only_block()); else passed++;
    endtask

    task automatic test_slot18();
        logic got;
        do_reset();
        for (int i = 0; i < 17; i++)
            send_word(32'h55000000 + 32'(i), 1'b0, 2'd0, got);
        send_word(32'h11223300, 1'b1, 2'd3, got);
        total++; if (out_ready !== 1'b1) $display("FAIL slot18_ready: got %b expected 1", out_ready); else passed++;
        total++; if (out[31:0] !== 32'h11223381) $display("FAIL slot18_word: got %h expected 11223381", out[31:0]); else passed++;
        total++; if (out[575:544] !== 32'h55000000) $display("FAIL slot18_first: got %h expected 55000000", out[575:544]); else passed++;
        f_ack = 1'b1;
        @(posedge clk); #1;
        f_ack    = 1'b0;
        in_ready = 1'b1;
        @(negedge clk);
        total++; if (ack !== 1'b0) $display("FAIL slot18_done_ack: got %b expected 0", ack); else passed++;
        @(posedge clk); #1;
        total++; if (out_ready !== 1'b0) $display("FAIL slot18_done_ready: got %b expected 0", out_ready); else passed++;
        in_ready = 1'b0;
    endtask

    task automatic test_fill_reset();
        logic got;
        do_reset();
        send_word(32'h12345678, 1'b1, 2'd2, got);
        repeat (3) @(posedge clk);
        #1;
        reset    = 1'b1;
        in_ready = 1'b1;
        @(negedge clk);
        total++; if (ack !== 1'b0) $display("FAIL fillrst_ack_in_reset: got %b expected 0", ack); else passed++;
        @(posedge clk); #1;
        reset = 1'b0;
        total++; if (out !== '0) $display("FAIL fillrst_out: got %h expected 0", out); else passed++;
        total++; if (out_ready !== 1'b0) $display("FAIL fillrst_ready: got %b expected 0", out_ready); else passed++;
        @(negedge clk);
        total++; if (ack !== 1'b1) $display("FAIL fillrst_ack: got %b expected 1", ack); else passed++;
        in_ready = 1'b0;
        @(negedge clk);
        total++; if (ack !== 1'b0) $display("FAIL fillrst_ack_low: got %b expected 0", ack); else passed++;
    endtask

    initial begin
        reset    = 1'b1;
        in       = '0;
        in_ready = 1'b0;
        is_last  = 1'b0;
        byte_num = 2'd0;
        f_ack    = 1'b0;
        test_reset();
        test_empty();
        test_three_byte();
        test_partial();
        test_back_to_back();
        test_slot18();
        test_fill_reset();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/block_padder.md
BLOCK_PADDER -- requirements
Module: block_padder

Interface
REQ-001 SHALL have port clk  input  1  single clock, all state updates on rising edge.
REQ-002 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-003 SHALL have port in  input  32  message word; first message byte in in[31:24].
REQ-004 SHALL have port in_ready  input  1  in and byte_num/is_last valid this cycle.
REQ-005 SHALL have port is_last  input  1  current word is the final (partial) word of the message.
REQ-006 SHALL have port byte_num  input  2  count of valid bytes in the final word (0..3); ignored when is_last=0.
REQ-007 SHALL have port ack  output  1  word presented on in is consumed this cycle.
REQ-008 SHALL have port out  output  576  assembled rate block for the permutation; first word in out[575:544].
REQ-009 SHALL have port out_ready  output  1  out holds a complete block.
REQ-010 SHALL have port f_ack  input  1  permutation has consumed out.
REQ-011 SHALL have parameter PAD_BYTE, default 8'h01, domain-separation byte placed after the final message byte.

Function
REQ-012 SHALL compute ack = in_ready & ~out_ready & ~last_seen combinationally.
REQ-013 SHALL on ack shift out left by 32 and place the (padded) word in out[31:0]; word counter increments by 1.
REQ-014 SHALL, for an ack with is_last=1, store in with bytes beyond byte_num replaced by PAD_BYTE in the next byte then zeros (byte_num=0 -> {PAD_BYTE,24'h0}; byte_num=3 -> {in[31:8],PAD_BYTE}), and set last_seen.
REQ-015 SHALL, while last_seen=1, counter<18 and out_ready=0, shift in a zero word each cycle without requiring in_ready (FILL).
REQ-016 SHALL OR 8'h80 into out[7:0] of the 18th word of the final block, whether that word is the last message word or a fill word (byte_num=3 at slot 18 with PAD_BYTE=01 yields 8'h81).
REQ-017 SHALL assert out_ready the cycle after the 18th word is written; out SHALL stay stable while out_ready=1.
REQ-018 SHALL on f_ack with out_ready=1 clear out_ready and counter next cycle; ack SHALL stay 0 in that same cycle (no simultaneous absorb).
REQ-019 SHALL ignore f_ack when out_ready=0.
REQ-020 SHALL after f_ack of the final block enter DONE: ack=0, out_ready=0, in ignored until reset.
REQ-021 SHALL implement states ABSORB -> (counter=18) FULL -> (f_ack) ABSORB; ABSORB -(is_last)-> FILL -> FULL_LAST -(f_ack)-> DONE; direct ABSORB -> FULL_LAST when is_last lands in slot 18.
REQ-022 SHALL produce exactly one extra all-padding block when a message ends exactly on a block boundary (next word presented with is_last=1, byte_num=0).

Reset
REQ-023 SHALL on reset clear out to 0, out_ready to 0, counter to 0, last_seen to 0, state to ABSORB, regardless of operation in progress.
REQ-024 SHALL keep ack=0 in any cycle where reset=1.

Structure
REQ-025 SHALL take RATE_WORDS=18, WORD_W=32, RATE_W=576 and state encoding from the shared keccak package.
REQ-026 SHALL place byte masking/PAD_BYTE insertion in one combinational sub-module pad_word(in, byte_num, is_last) -> 32-bit word.
REQ-027 SHALL connect out/out_ready/f_ack directly to the permutation's in/in_ready/ack with no glue.

Verification
REQ-028 Empty message: is_last=1, byte_num=0 -> out_ready after 18 cycles, out = {32'h01000000, 16x32'h0, 32'h00000080}.
REQ-029 3-byte message 0xAABBCC: in=32'hAABBCC00, is_last=1, byte_num=3 -> first word 32'hAABBCC01, last word 32'h00000080.
REQ-030 18 full words then is_last, byte_num=0 -> block 1 holds words verbatim; after f_ack, block 2 = padding-only as REQ-028.
REQ-031 17 full words then is_last, byte_num=3, in=32'h11223300 -> word 18 = 32'h11223381, out_ready next cycle.
REQ-032 in_ready held high while out_ready=1 and f_ack pulses -> ack=0 during full and f_ack cycles, no word lost or duplicated.
REQ-033 reset asserted mid-FILL -> next cycle out=0, out_ready=0, ack follows in_ready.
